// File: rtl/imem_loader_if.sv
// imem_loader_if: host-to-loader byte stream, valid/ready handshake.
// master = host side (drives in_valid/in_data), slave = loader side (drives in_ready).
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream (count, words, xor checksum) into 32-bit
// instruction-memory writes and releases core_rst only after a verified load.
// Ports: clk, rst (sync, active high), start; bs (byte stream, slave);
//   mem_we/mem_addr/mem_wdata (imem write); core_rst, busy, done, err, words_loaded.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   imem_loader_if.slave      bs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(2**ADDR_W);

   state_t      state_q;
   state_t      state_d;
   logic [15:0] cnt_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] word_q;
   logic [7:0]  chk_q;

   logic        hs;
   logic        restart;
   logic        last_word;
   logic [15:0] n_rx;
   logic [16:0] wl_next;

   assign bs.in_ready = busy;
   assign hs          = bs.in_valid & busy;
   assign n_rx        = {cnt_q[15:8], bs.in_data};

   // words_loaded already counts every finished word when the next
   // word's 4th byte arrives (writes are at least 4 cycles apart).
   assign wl_next   = 17'(words_loaded) + 17'd1;
   assign last_word = (byte_idx_q == 2'd3) &&
                      (wl_next == {1'b0, cnt_q});

   assign restart = start &&
                    (state_q == S_IDLE ||
                     state_q == S_DONE ||
                     state_q == S_ERR);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and state-decoded outputs
   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      core_rst = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CNT_HI;
         end
         S_CNT_HI: begin
            busy = 1'b1;
            if (hs) state_d = S_CNT_LO;
         end
         S_CNT_LO: begin
            busy = 1'b1;
            if (hs) begin
               if ({1'b0, n_rx} > MAX_N) begin
                  state_d = S_ERR;
               end else if (n_rx == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            busy = 1'b1;
            if (hs && last_word) state_d = S_CHECK;
         end
         S_CHECK: begin
            busy = 1'b1;
            if (hs) begin
               if (bs.in_data == chk_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_DONE: begin
            done     = 1'b1;
            core_rst = 1'b0;
            if (start) state_d = S_CNT_HI;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_d = S_CNT_HI;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // datapath: count, word packing, checksum, write strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         chk_q        <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         words_loaded <= '0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we) begin
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
         end
         if (restart) begin
            words_loaded <= '0;
            chk_q        <= '0;
            byte_idx_q   <= '0;
         end
         if (hs) begin
            unique case (state_q)
               S_CNT_HI: begin
                  cnt_q[15:8] <= bs.in_data;
                  chk_q       <= chk_q ^ bs.in_data;
               end
               S_CNT_LO: begin
                  cnt_q[7:0] <= bs.in_data;
                  chk_q      <= chk_q ^ bs.in_data;
               end
               S_DATA: begin
                  chk_q      <= chk_q ^ bs.in_data;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= words_loaded[ADDR_W-1:0];
                     mem_wdata <= {word_q, bs.in_data};
                  end else begin
                     word_q <= {word_q[15:0], bs.in_data};
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a stream-level model
// (expected writes and final status derived from the byte stream itself).
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader_if bs ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bs           (bs),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   logic [31:0]       mem_img[DEPTH];
   int                wr_cnt    = 0;
   int                last_addr = -1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      check("in_ready_vs_busy", bs.in_ready, busy);
      check("core_rst_vs_done", core_rst, !done);
      check("words_loaded_cyc", words_loaded, wr_cnt);
      if (mem_we) begin
         check("write_expected", exp_addr.size() != 0, 1);
         if (exp_addr.size() != 0) begin
            check("wr_addr", mem_addr, exp_addr.pop_front());
            check("wr_data", mem_wdata, exp_data.pop_front());
         end
         mem_img[mem_addr] = mem_wdata;
         last_addr = int'(mem_addr);
         wr_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] xor_all(input bq_t s, input int len);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < len; i++) x ^= s[i];
      return x;
   endfunction

   function automatic bq_t make_stream(input wq_t w, input bit bad);
      bq_t s;
      int n = w.size();
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
         s.push_back(w[k][31:24]);
         s.push_back(w[k][23:16]);
         s.push_back(w[k][15:8]);
         s.push_back(w[k][7:0]);
      end
      s.push_back(xor_all(s, s.size()) ^ (bad ? 8'h01 : 8'h00));
      return s;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, bs.in_ready, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_core_rst"}, core_rst, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_words"}, words_loaded, 0);
   endtask

   task automatic send_byte(input logic [7:0] b,
                            input int max_gap,
                            input bit noise);
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int i = 0; i < gap; i++) begin
         bs.in_valid = 1'b0;
         bs.in_data  = 8'($urandom);
         start = noise && ($urandom_range(0, 2) == 0);
         tick();
      end
      start       = 1'b0;
      bs.in_valid = 1'b1;
      bs.in_data  = b;
      t = 0;
      while (!bs.in_ready && t < 50) begin
         tick();
         t++;
      end
      check("handshake_ready", bs.in_ready, 1);
      tick();
      bs.in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start  = 1'b0;
      wr_cnt = 0;
      check("start_core_rst", core_rst, 1);
      check("start_busy", busy, 1);
      check("start_done", done, 0);
      check("start_err", err, 0);
      check("start_words", words_loaded, 0);
   endtask

   // model: writes and outcome follow from the stream bytes alone
   task automatic run_load(input bq_t s, input int max_gap, input bit noise);
      int n;
      int nb;
      bit ok;
      n = int'({s[0], s[1]});
      exp_addr.delete();
      exp_data.delete();
      if (n > DEPTH) begin
         nb = 2;
         ok = 1'b0;
      end else begin
         nb = 2 + 4 * n + 1;
         ok = (s[nb-1] == xor_all(s, nb - 1));
         for (int k = 0; k < n; k++) begin
            exp_addr.push_back(ADDR_W'(k));
            exp_data.push_back({s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
         end
      end
      do_start();
      for (int i = 0; i < nb; i++) send_byte(s[i], max_gap, noise);
      tick();
      check("end_done", done, ok);
      check("end_err", err, !ok);
      check("end_core_rst", core_rst, !ok);
      check("end_busy", busy, 0);
      check("end_words", words_loaded, (n > DEPTH) ? 0 : n);
      check("end_writes_left", exp_addr.size(), 0);
   endtask

   task automatic offer_idle_byte(input string tag);
      logic d0, e0;
      d0 = done;
      e0 = err;
      bs.in_valid = 1'b1;
      bs.in_data  = 8'hA5;
      repeat (3) tick();
      bs.in_valid = 1'b0;
      check({tag, "_done_hold"}, done, d0);
      check({tag, "_err_hold"}, err, e0);
      check({tag, "_busy_hold"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bq_t s1;
      bq_t s;
      wq_t w;

      bs.in_valid = 1'b0;
      bs.in_data  = 8'h00;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_reset_vals("reset");

      // bytes offered in IDLE are ignored
      offer_idle_byte("idle");

      // scenario 1: stream checksum is XOR of all preceding bytes = 0x65
      s1 = {8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h20, 8'h43, 8'h00, 8'h05, 8'h65};
      check("model_xor", xor_all(s1, 10), 8'h65);
      run_load(s1, 0, 1'b0);
      check("s1_img0", mem_img[0], 32'h00000001);
      check("s1_img1", mem_img[1], 32'h20430005);
      check("s1_words", words_loaded, 2);
      offer_idle_byte("done");

      // scenario 2: bad checksum
      s = s1;
      s[10] = 8'h67;
      mem_img[0] = '0;
      mem_img[1] = '0;
      run_load(s, 0, 1'b0);
      check("s2_err", err, 1);
      check("s2_img1", mem_img[1], 32'h20430005);

      // scenario 3: empty image, then oversize count
      s = {8'h00, 8'h00, 8'h00};
      run_load(s, 0, 1'b0);
      check("s3_done", done, 1);
      s = {8'h04, 8'h01};
      run_load(s, 0, 1'b0);
      check("s3_err", err, 1);
      offer_idle_byte("err");

      // scenario 4: gaps and ignored start pulses
      run_load(s1, 3, 1'b1);
      check("s4_done", done, 1);

      // scenario 5: reset after the 6th byte
      mem_img[1] = 32'hDEADBEEF;
      exp_addr.delete();
      exp_data.delete();
      exp_addr.push_back('0);
      exp_data.push_back(32'h00000001);
      do_start();
      for (int i = 0; i < 6; i++) send_byte(s1[i], 0, 1'b0);
      check("s5_we", mem_we, 1);
      check("s5_addr", mem_addr, 0);
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      wr_cnt = 0;
      check_reset_vals("midrst");
      repeat (8) tick();
      check("s5_img1", mem_img[1], 32'hDEADBEEF);
      check("s5_writes_left", exp_addr.size(), 0);

      // randomized loads
      for (int r = 0; r < 8; r++) begin
         w.delete();
         for (int k = 0; k < int'($urandom_range(1, 16)); k++)
            w.push_back($urandom);
         run_load(make_stream(w, $urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 3)), 1'b1);
      end

      // scenario 6: full memory, then restart with one word
      w.delete();
      for (int k = 0; k < DEPTH; k++) w.push_back(32'(k));
      run_load(make_stream(w, 1'b0), 1, 1'b0);
      check("s6_last_addr", last_addr, DEPTH - 1);
      check("s6_img_last", mem_img[DEPTH-1], DEPTH - 1);
      check("s6_done", done, 1);
      w.delete();
      w.push_back(32'hFFFFFFFF);
      run_load(make_stream(w, 1'b0), 2, 1'b0);
      check("s6_img0", mem_img[0], 32'hFFFFFFFF);
      check("s6_done2", done, 1);
      check("s6_words", words_loaded, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
